mult_seq_ctrl: RTL and testbench

//   Sequential signed multiplier controller. Accepts M x N two's-complement operand

---
 rtl/mult_seq_ctrl_if.sv | 37 +++
 rtl/mult_seq_ctrl.sv | 152 +++++++++++++++
 tb/tb_mult_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Operand/product handshake bundle for the sequential signed multiplier.
// The slave side is the multiplier. The master side is whoever drives
// the requests and consumes the products.
interface mult_seq_ctrl_if #(
  parameter int M = 5,
  parameter int N = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [M-1:0]     req0_a;
  logic [N-1:0]     req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [M-1:0]     req1_a;
  logic [N-1:0]     req1_b;
  logic             out_valid;
  logic             out_ready;
  logic [M+N-1:0]   out_prod;
  logic             out_id;
  logic             busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_prod, out_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_prod, out_id, busy
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential signed multiplier controller.
// Two requesters share one shift-add datapath through a round-robin arbiter.
// The datapath multiplies operand magnitudes over N iterations, and the
// product sign is applied in a single final step.
module mult_seq_ctrl #(
  parameter int M = 5,
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mult_seq_ctrl_if.slave     bus
);

  localparam int W  = M + N;          // product / accumulator width
  localparam int BW = N + 1;          // |b| needs one extra bit for the most negative b
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    state;
  logic [W-1:0]  a_reg;
  logic [BW-1:0] b_reg;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          sign;
  logic          id;
  logic          rr_last;

  logic          out_valid;
  logic [W-1:0]  out_prod;
  logic          out_id;

  logic          grant;
  logic          ready0;
  logic          ready1;
  logic          accept;
  logic [M-1:0]  sel_a;
  logic [N-1:0]  sel_b;
  logic [W-1:0]  a_ext;
  logic [W-1:0]  a_mag;
  logic [BW-1:0] b_ext;
  logic [BW-1:0] b_mag;
  logic          last_iter;

  // Round-robin grant and the combinational accept handshake (IDLE only).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~rr_last;
    end else if (bus.req1_valid) begin
      grant = 1'b1;
    end
    ready0 = (state == S_IDLE) && bus.req0_valid && !grant;
    ready1 = (state == S_IDLE) && bus.req1_valid &&  grant;
    accept = ready0 || ready1;
  end

  // Operand magnitudes of the granted requester.
  always_comb begin
    sel_a = grant ? bus.req1_a : bus.req0_a;
    sel_b = grant ? bus.req1_b : bus.req0_b;
    // The operands are sign-extended before negation, so the most negative value
    // (e.g. -16) becomes its true magnitude (16) rather than wrapping.
    a_ext = {{N{sel_a[M-1]}}, sel_a};
    b_ext = {sel_b[N-1], sel_b};
    a_mag = sel_a[M-1] ? (~a_ext + W'(1))  : a_ext;
    b_mag = sel_b[N-1] ? (~b_ext + BW'(1)) : b_ext;
  end

  assign last_iter = (cnt == CW'(N - 1));

  // Control FSM: IDLE -> ITER (N edges) -> SIGN -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      case (state)
        S_IDLE:  if (accept)                     state <= S_ITER;
        S_ITER:  if (last_iter)                  state <= S_SIGN;
        S_SIGN:                                  state <= S_DONE;
        S_DONE:  if (bus.out_ready)              state <= S_IDLE;
        default:                                 state <= S_IDLE;
      endcase
    end
  end

  // Operand capture on accept, then one shift-add step per ITER cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset as well, so a reset in mid-operation leaves no trace of the aborted product.
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      id      <= 1'b0;
      rr_last <= 1'b1;                       // requester 0 wins the first tie
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            a_reg   <= a_mag;
            b_reg   <= b_mag;
            acc     <= '0;
            cnt     <= '0;
            sign    <= sel_a[M-1] ^ sel_b[N-1];
            id      <= grant;
            rr_last <= grant;
          end
        end
        S_ITER: begin
          acc   <= acc + (b_reg[0] ? a_reg : '0);
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          cnt   <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Output register: loaded in SIGN, held through DONE until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      out_id    <= 1'b0;
    end else begin
      if (state == S_SIGN) begin
        // Negating a zero accumulator gives zero, so a zero product with sign=1 stays 0.
        out_prod  <= sign ? (~acc + W'(1)) : acc;
        out_id    <= id;
        out_valid <= 1'b1;
      end else if (state == S_DONE && bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.out_valid  = out_valid;
  assign bus.out_prod   = out_prod;
  assign bus.out_id     = out_id;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl.
// Drivers push expected products into a scoreboard when a request is
// accepted. A monitor pops and compares whenever a product is handed off.
module tb_mult_seq_ctrl;

  localparam int M = 5;
  localparam int N = 4;
  localparam int W = M + N;

  typedef struct {
    logic [W-1:0] prod;
    logic         id;
    int           acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;

  mult_seq_ctrl_if #(.M(M), .N(N)) bus ();

  mult_seq_ctrl #(.M(M), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;            // 0: out_ready=1, 1: out_ready=0, 2: random
  exp_t sb[$];
  logic accept_log[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain signed multiplication, truncated to the product width.
  function automatic logic [W-1:0] ref_prod(input logic [M-1:0] a, input logic [N-1:0] b);
    int p;
    p = $signed(a) * $signed(b);
    return p[W-1:0];
  endfunction

  // Offer one operand pair on a requester until accepted, then scramble the inputs.
  task automatic send_exp(input logic id, input logic [M-1:0] a, input logic [N-1:0] b,
                          input logic [W-1:0] e);
    int   waited;
    bit   got;
    exp_t x;
    waited = 0;
    got    = 0;
    @(posedge clk); #1;
    if (id) begin bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1; end
    else    begin bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1; end
    while (!got && waited < 300) begin
      @(negedge clk);
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        got       = 1;
        x.prod    = e;
        x.id      = id;
        x.acc_cyc = cyc + 1;   // cycle count after the accept edge
        sb.push_back(x);
        accept_log.push_back(id);
      end else begin
        waited++;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: requester %0d got no ready, expected an accept", id);
    end
    @(posedge clk); #1;
    if (id) begin bus.req1_valid = 1'b0; bus.req1_a = M'($urandom); bus.req1_b = N'($urandom); end
    else    begin bus.req0_valid = 1'b0; bus.req0_a = M'($urandom); bus.req0_b = N'($urandom); end
  endtask

  task automatic send(input logic id, input logic [M-1:0] a, input logic [N-1:0] b);
    send_exp(id, a, b, ref_prod(a, b));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d products still pending, expected 0", sb.size());
    end
  endtask

  // Consumer ready generator.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: handshake rules, hold stability, latency and scoreboard compare.
  logic         prev_valid = 1'b0;
  logic         stalled    = 1'b0;
  logic [W-1:0] held_prod;
  logic         held_id;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      stalled    = 1'b0;
    end else begin
      if (bus.busy)
        check("ready_low_when_busy", {30'd0, bus.req0_ready, bus.req1_ready}, 32'd0);
      if (stalled) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_prod",  bus.out_prod, held_prod);
        check("hold_id",    bus.out_id, held_id);
      end
      if (bus.out_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: prod %0h with empty scoreboard", bus.out_prod);
        end else begin
          check("latency", cyc - sb[0].acc_cyc, N + 1);
        end
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("product", bus.out_prod, e.prod);
        check("out_id",  bus.out_id, e.id);
      end
      stalled    = bus.out_valid && !bus.out_ready;
      held_prod  = bus.out_prod;
      held_id    = bus.out_id;
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_prod",  bus.out_prod, 0);
    check("reset_out_id",    bus.out_id, 0);
    check("reset_busy",      bus.busy, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Both requesters always valid from reset: grants alternate starting with 0.
    accept_log.delete();
    fork
      for (int i = 0; i < 3; i++) send(1'b0, M'($urandom), N'($urandom));
      for (int i = 0; i < 3; i++) send(1'b1, M'($urandom), N'($urandom));
    join
    drain();
    check("alt_count", accept_log.size(), 6);
    for (int i = 0; i < accept_log.size(); i++)
      check("alt_order", accept_log[i], i % 2);

    // Basic product and latency.
    send_exp(1'b0, 5'h03, 4'hE, 9'h1FA);
    drain();

    // Corner magnitudes.
    send_exp(1'b1, 5'h10, 4'h8, 9'h080);
    send_exp(1'b0, 5'h0F, 4'h7, 9'h069);
    send_exp(1'b1, 5'h10, 4'h7, 9'h190);
    send_exp(1'b0, 5'h00, 4'h8, 9'h000);
    drain();

    // Consumer stall in DONE, with requester 0 waiting behind it.
    rdy_mode = 1;
    @(posedge clk);
    send_exp(1'b1, 5'h1D, 4'h5, 9'h1F1);
    fork
      send_exp(1'b0, 5'h04, 4'hF, 9'h1FC);
    join_none
    for (int i = 0; i < 50 && !bus.out_valid; i++) @(negedge clk);
    check("stall_out_valid", bus.out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_readies", {bus.req0_ready, bus.req1_ready}, 0);
    end
    rdy_mode = 0;
    @(posedge clk); #2;
    @(negedge clk);
    @(negedge clk);
    check("release_idle", bus.busy, 0);
    check("release_accept_next", bus.req0_ready, 1);
    wait fork;
    drain();

    // Reset in the middle of ITER aborts the in-flight product.
    send_exp(1'b0, 5'h07, 4'h3, 9'h015);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_busy",      bus.busy, 0);
    check("abort_out_prod",  bus.out_prod, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send_exp(1'b0, 5'h02, 4'h3, 9'h006);
    drain();

    // Random operands from both requesters with random consumer stalls.
    rdy_mode = 2;
    fork
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 8)) @(posedge clk);
        send(1'b0, M'($urandom), N'($urandom));
      end
      for (int i = 0; i < 20; i++) begin
        repeat ($urandom_range(0, 8)) @(posedge clk);
        send(1'b1, M'($urandom), N'($urandom));
      end
    join
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
